// File: rtl/drive_data.sv
// Output-pin driver for the IO controller: static level, single timed pulse, or
// continuous square wave, with a sticky maskable completion interrupt.
module drive_data #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             level,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic             clr,
  input  logic             interrupt_mask,
  output logic             pin_out,
  output logic             busy,
  output logic             irq
);

  localparam logic [1:0] M_PULSE = 2'b01;
  localparam logic [1:0] M_WAVE  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_REST} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [1:0]       mode_q;
  logic             level_q;
  logic             pin_q;
  logic             busy_q;
  logic             irq_q;
  logic             done_d;

  // A zero length is treated as one cycle, so the reload is max(len,1)-1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_comb begin
    done_d = 1'b0;
    if (enable && state_q != S_IDLE) begin
      if (stop)
        done_d = 1'b1;
      else if (state_q == S_ACTIVE && cnt_q == '0 && mode_q == M_PULSE)
        done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      mode_q  <= '0;
      level_q <= 1'b0;
      pin_q   <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else if (enable) begin
      // Set has priority over clear when both happen in the same cycle.
      if (done_d && interrupt_mask)
        irq_q <= 1'b1;
      else if (clr)
        irq_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          pin_q <= level;
          if (start && !stop && (mode == M_PULSE || mode == M_WAVE)) begin
            mode_q  <= mode;
            level_q <= level;
            high_q  <= high_len;
            low_q   <= low_len;
            cnt_q   <= len_m1(high_len);
            pin_q   <= ~level;
            state_q <= S_ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (stop) begin
            pin_q   <= level_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (mode_q == M_PULSE) begin
            pin_q   <= level_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            pin_q   <= level_q;
            cnt_q   <= len_m1(low_q);
            state_q <= S_REST;
          end
        end
        S_REST: begin
          if (stop) begin
            pin_q   <= level_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            pin_q   <= ~level_q;
            cnt_q   <= len_m1(high_q);
            state_q <= S_ACTIVE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pin_out = pin_q;
  assign busy    = busy_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_drive_data.sv
// Scoreboard bench for drive_data: stimulus queues hand-computed {pin_out,busy,irq}
// expectations tagged with the cycle they are due; a negedge monitor compares them.
module tb_drive_data;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [1:0]       mode;
  logic             level;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             clr;
  logic             interrupt_mask;
  logic             pin_out;
  logic             busy;
  logic             irq;

  drive_data #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .mode           (mode),
    .level          (level),
    .start          (start),
    .stop           (stop),
    .high_len       (high_len),
    .low_len        (low_len),
    .clr            (clr),
    .interrupt_mask (interrupt_mask),
    .pin_out        (pin_out),
    .busy           (busy),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic [2:0] exp;
    int   id;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   test_id  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {pin,busy,irq} got=%b expected=%b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation whose due cycle has been reached.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("test%0d", e.id), {pin_out, busy, irq}, e.exp);
    end
  end

  // Inputs are already set; queue the state expected after the coming edge.
  task automatic step(input logic p, input logic b, input logic i);
    exp_t e;
    e.due = cyc + 1;
    e.exp = {p, b, i};
    e.id  = test_id;
    sb.push_back(e);
    @(posedge clk);
    #2;
    start = 1'b0;
    stop  = 1'b0;
    clr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; level = 1'b0;
    start = 1'b0; stop = 1'b0; clr = 1'b0; interrupt_mask = 1'b1;
    high_len = '0; low_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {pin_out, busy, irq}, 3'b000);
    #1;
    rst_n = 1'b1;

    // 1: static level, reserved mode treated as static
    test_id = 1;
    enable = 1'b1; mode = 2'b00; level = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    level = 1'b0;
    step(0, 0, 0);
    mode = 2'b11; level = 1'b1; start = 1'b1;
    step(1, 0, 0);

    // 2: 5-cycle pulse, irq, clr
    test_id = 2;
    mode = 2'b01; level = 1'b0; high_len = 16'd5; start = 1'b1;
    repeat (5) step(1, 1, 0);
    step(0, 0, 1);
    clr = 1'b1;
    step(0, 0, 0);

    // 3: wave 3/2 for 4+ periods, mid-run level change ignored, stop in ACTIVE
    test_id = 3;
    mode = 2'b10; level = 1'b0; high_len = 16'd3; low_len = 16'd2; start = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k == 1) level = 1'b1;
      step((k % 5) < 3, 1, 0);
    end
    stop = 1'b1;
    step(0, 0, 1);
    clr = 1'b1;
    step(1, 0, 0);

    // 4: zero length pulse, no retrigger, start+stop from IDLE
    test_id = 4;
    mode = 2'b01; level = 1'b0; high_len = 16'd0; start = 1'b1;
    step(1, 1, 0);
    step(0, 0, 1);
    clr = 1'b1;
    step(0, 0, 0);
    high_len = 16'd3; start = 1'b1;
    step(1, 1, 0);
    start = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    clr = 1'b1;
    step(0, 0, 0);
    start = 1'b1; stop = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // 5: enable freeze mid-pulse, clr ignored while disabled
    test_id = 5;
    high_len = 16'd4; start = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    enable = 1'b0;
    repeat (4) begin
      start = 1'b1;
      step(1, 1, 0);
    end
    enable = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    enable = 1'b0; clr = 1'b1;
    step(0, 0, 1);
    enable = 1'b1; clr = 1'b1;
    step(0, 0, 0);

    // 6: masked completion, clr vs set priority, mask clear keeps irq, async reset
    test_id = 6;
    interrupt_mask = 1'b0; high_len = 16'd2; start = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    interrupt_mask = 1'b1; high_len = 16'd1; start = 1'b1;
    step(1, 1, 0);
    clr = 1'b1;
    step(0, 0, 1);
    interrupt_mask = 1'b0;
    step(0, 0, 1);
    clr = 1'b1;
    step(0, 0, 0);
    interrupt_mask = 1'b1; mode = 2'b10; high_len = 16'd3; low_len = 16'd2; start = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {pin_out, busy, irq}, 3'b000);
    @(posedge clk);
    #1;
    chk("reset_hold", {pin_out, busy, irq}, 3'b000);
    rst_n = 1'b1;

    @(negedge clk);
    #1;
    chk("scoreboard_drained", {1'b0, sb.size() == 0, 1'b0}, 3'b010);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
